// File: rtl/relu_maxpool2x2.sv
// ReLU followed by 2x2 / stride-2 max pooling over a raster-ordered CO-channel map.
// A half-row buffer keeps the even-row pair maxima, so input may arrive with arbitrary gaps.
module relu_maxpool2x2 #(
  parameter int CO   = 3,
  parameter int I_BW = 23,
  parameter int OW   = 24,
  parameter int OH   = 24,
  parameter int CW   = 5,
  parameter int RW   = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_clear,
  input  logic                 i_in_valid,
  input  logic [CO*I_BW-1:0]   i_in_fmap,
  output logic                 o_ot_valid,
  output logic [CO*I_BW-1:0]   o_ot_fmap,
  output logic                 o_frame_done
);

  localparam int FW = CO * I_BW;
  localparam int PW = OW / 2;
  localparam int AW = (PW > 1) ? $clog2(PW) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(OW - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(OH - 1);

  function automatic logic [I_BW-1:0] relu(input logic signed [I_BW-1:0] x);
    return x[I_BW-1] ? '0 : x;
  endfunction

  function automatic logic [I_BW-1:0] umax(input logic [I_BW-1:0] a, input logic [I_BW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [FW-1:0] relu_vec(input logic [FW-1:0] x);
    logic [FW-1:0] r;
    r = '0;
    for (int c = 0; c < CO; c++) r[c*I_BW +: I_BW] = relu(x[c*I_BW +: I_BW]);
    return r;
  endfunction

  function automatic logic [FW-1:0] max_vec(input logic [FW-1:0] a, input logic [FW-1:0] b);
    logic [FW-1:0] r;
    r = '0;
    for (int c = 0; c < CO; c++) r[c*I_BW +: I_BW] = umax(a[c*I_BW +: I_BW], b[c*I_BW +: I_BW]);
    return r;
  endfunction

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [FW-1:0] hold;
  logic [FW-1:0] rowbuf [PW];

  logic          acc_p0;
  logic          col_last_p0;
  logic          row_last_p0;
  logic          hold_we_p0;
  logic          buf_we_p0;
  logic          pool_p0;
  logic [AW-1:0] bidx_p0;
  logic [FW-1:0] relu_p0;
  logic [FW-1:0] pair_p0;
  logic [FW-1:0] pool_val_p0;

  logic          vld_p1;
  logic [FW-1:0] fmap_p1;
  logic          done_p1;

  // Stage p0: ReLU, column pairing and row combine, all from the current pixel
  always_comb begin
    acc_p0      = i_in_valid & ~i_clear;
    col_last_p0 = (col == COL_LAST);
    row_last_p0 = (row == ROW_LAST);
    // The trailing column of an odd-width map and the trailing row of an
    // odd-height map are never part of a complete block.
    hold_we_p0  = acc_p0 & ~col[0] & ~col_last_p0;
    buf_we_p0   = acc_p0 & col[0] & ~row[0] & ~row_last_p0;
    pool_p0     = acc_p0 & col[0] & row[0];
    bidx_p0     = AW'(col >> 1);
    relu_p0     = relu_vec(i_in_fmap);
    pair_p0     = max_vec(hold, relu_p0);
    pool_val_p0 = max_vec(rowbuf[bidx_p0], pair_p0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col     <= '0;
      row     <= '0;
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
    end else if (i_clear) begin
      col     <= '0;
      row     <= '0;
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
    end else begin
      vld_p1  <= pool_p0;
      done_p1 <= acc_p0 & col_last_p0 & row_last_p0;
      if (acc_p0) begin
        if (col_last_p0) begin
          col <= '0;
          row <= row_last_p0 ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold <= '0;
    end else if (i_clear) begin
      hold <= '0;
    end else if (hold_we_p0) begin
      hold <= relu_p0;
    end
  end

  // Row buffer is always rewritten on an even row before being read, so clear leaves it alone
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PW; i++) rowbuf[i] <= '0;
    end else if (buf_we_p0) begin
      rowbuf[bidx_p0] <= pair_p0;
    end
  end

  // Stage p1: registered pooled pixel, held between valid pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fmap_p1 <= '0;
    end else if (pool_p0) begin
      fmap_p1 <= pool_val_p0;
    end
  end

  assign o_ot_valid   = vld_p1;
  assign o_ot_fmap    = fmap_p1;
  assign o_frame_done = done_p1;

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Bench for relu_maxpool2x2: a 4x4 and a 5x5 instance share stimulus; a frame-image
// reference model predicts every cycle, plus constant tables for the directed frames.
module tb_relu_maxpool2x2;

  localparam int CO   = 3;
  localparam int I_BW = 23;
  localparam int FW   = CO * I_BW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic [FW-1:0] in_fmap = '0;
  logic          v4, d4, v5, d5;
  logic [FW-1:0] f4, f5;
  logic          sel = 1'b0;
  logic          ov, od;
  logic [FW-1:0] of;

  always #5 clk = ~clk;

  relu_maxpool2x2 #(.CO(CO), .I_BW(I_BW), .OW(4), .OH(4), .CW(2), .RW(2)) dut4 (
    .clk(clk), .reset_n(reset_n), .i_clear(clear), .i_in_valid(in_valid),
    .i_in_fmap(in_fmap), .o_ot_valid(v4), .o_ot_fmap(f4), .o_frame_done(d4));

  relu_maxpool2x2 #(.CO(CO), .I_BW(I_BW), .OW(5), .OH(5), .CW(3), .RW(3)) dut5 (
    .clk(clk), .reset_n(reset_n), .i_clear(clear), .i_in_valid(in_valid),
    .i_in_fmap(in_fmap), .o_ot_valid(v5), .o_ot_fmap(f5), .o_frame_done(d5));

  assign ov = sel ? v5 : v4;
  assign of = sel ? f5 : f4;
  assign od = sel ? d5 : d4;

  int            vectors = 0;
  int            miscompares = 0;
  int            mow = 4, moh = 4, mc = 0, mr = 0;
  logic [FW-1:0] img [8][8];
  logic [FW-1:0] last_f = '0;
  logic [FW-1:0] got [$];

  typedef struct {
    int   pix;
    logic ev;
    int   eo;
    logic ed;
  } vec_t;
  vec_t tbl [16];

  function automatic logic [I_BW-1:0] m_relu(input logic [I_BW-1:0] x);
    return x[I_BW-1] ? '0 : x;
  endfunction

  function automatic logic [FW-1:0] pk(input int a, input int b, input int c);
    return {I_BW'(c), I_BW'(b), I_BW'(a)};
  endfunction

  task automatic check(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model works from the whole stored frame image
  task automatic step(input logic v, input logic c, input logic [FW-1:0] d);
    logic          ev, ed;
    logic [I_BW-1:0] m, p;
    in_valid = v; clear = c; in_fmap = d;
    ev = 1'b0; ed = 1'b0;
    if (c) begin
      mc = 0; mr = 0;
    end else if (v) begin
      img[mr][mc] = d;
      if (mr % 2 == 1 && mc % 2 == 1) begin
        ev = 1'b1;
        for (int ch = 0; ch < CO; ch++) begin
          m = '0;
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) begin
              p = m_relu(img[mr-dr][mc-dc][ch*I_BW +: I_BW]);
              if (p > m) m = p;
            end
          last_f[ch*I_BW +: I_BW] = m;
        end
      end
      if (mc == mow - 1 && mr == moh - 1) ed = 1'b1;
      mc++;
      if (mc == mow) begin
        mc = 0; mr++;
        if (mr == moh) mr = 0;
      end
    end
    @(posedge clk); #1;
    check("valid", FW'(ov), FW'(ev));
    check("fmap", of, last_f);
    check("done", FW'(od), FW'(ed));
    if (ov) got.push_back(of);
    in_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_valid", FW'(ov), '0);
    check("rst_fmap", of, '0);
    check("rst_done", FW'(od), '0);
    mc = 0; mr = 0; last_f = '0;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic feed_frame(input int npix, input int base, input logic gaps);
    for (int i = 0; i < npix; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, '0);
      step(1'b1, 1'b0, pk(i + base, 15 - i, -i));
    end
  endtask

  task automatic expect4(input string nm, input int ch, input int e[4]);
    check({nm, "_count"}, FW'(got.size()), FW'(4));
    for (int i = 0; i < 4; i++)
      if (i < got.size()) check(nm, FW'(got[i][ch*I_BW +: I_BW]), FW'(e[i]));
  endtask

  initial begin
    int vals [16];
    for (int i = 0; i < 16; i++) begin
      tbl[i].pix = i;
      tbl[i].ev  = (i == 5 || i == 7 || i == 13 || i == 15);
      tbl[i].eo  = (i >= 15) ? 15 : (i >= 13) ? 13 : (i >= 7) ? 7 : (i >= 5) ? 5 : 0;
      tbl[i].ed  = (i == 15);
    end
    vals = '{9, -3, -3, -3, -3, -3, -3, 9, -3, -3, -1, -100, -3, 9, -5, -7};

    do_reset();

    // Plain 0..15 raster against the constant table
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, pk(tbl[i].pix, 0, 0));
      check("t1_valid", FW'(ov), FW'(tbl[i].ev));
      check("t1_out", FW'(of[I_BW-1:0]), FW'(tbl[i].eo));
      check("t1_done", FW'(od), FW'(tbl[i].ed));
    end
    got.delete();

    // Negative values: one positive per block, last block all negative
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, pk(vals[i], vals[i], vals[i]));
    expect4("t2_ch0", 0, '{9, 9, 9, 0});
    expect4("t2_ch2", 2, '{9, 9, 9, 0});
    got.delete();

    // Three differing channels with random gaps
    feed_frame(16, 0, 1'b1);
    expect4("t3_ch0", 0, '{5, 7, 13, 15});
    expect4("t3_ch1", 1, '{15, 13, 7, 5});
    expect4("t3_ch2", 2, '{0, 0, 0, 0});
    got.delete();

    // Back-to-back frames
    feed_frame(16, 0, 1'b0);
    expect4("t4_a", 0, '{5, 7, 13, 15});
    got.delete();
    feed_frame(16, 100, 1'b0);
    expect4("t4_b", 0, '{105, 107, 113, 115});
    got.delete();

    // Odd 5x5 map
    sel = 1'b1; mow = 5; moh = 5;
    do_reset();
    feed_frame(25, 0, 1'b0);
    expect4("t5", 0, '{6, 8, 16, 18});
    got.delete();

    // Clear mid-frame, clear beating a valid pixel
    sel = 1'b0; mow = 4; moh = 4;
    do_reset();
    feed_frame(6, 50, 1'b0);
    step(1'b1, 1'b1, pk(77, 77, 77));
    got.delete();
    feed_frame(16, 0, 1'b0);
    expect4("t6_clr", 0, '{5, 7, 13, 15});
    got.delete();

    // Reset mid-frame
    feed_frame(6, 50, 1'b0);
    do_reset();
    got.delete();
    feed_frame(16, 0, 1'b0);
    expect4("t6_rst", 0, '{5, 7, 13, 15});
    got.delete();

    // Randomized data, gaps and clears on both geometries
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1); mow = (s == 1) ? 5 : 4; moh = mow;
      do_reset();
      for (int n = 0; n < 400; n++) begin
        if ($urandom_range(0, 39) == 0)
          step($urandom_range(0, 1) == 1, 1'b1, FW'({$urandom, $urandom, $urandom}));
        else if ($urandom_range(0, 3) == 0)
          step(1'b0, 1'b0, FW'({$urandom, $urandom, $urandom}));
        else
          step(1'b1, 1'b0, FW'({$urandom, $urandom, $urandom}));
      end
      got.delete();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
